// File: rtl/pipeline_register.sv
// pipeline_register
//   DEPTH-stage valid/ready register pipeline with bubble collapsing.
//   An entry can advance into any stage that is empty, or whose current
//   occupant is itself advancing, so gaps close up while the output is stalled.
//
// Parameters
//   WIDTH        data bits per stage (>= 1)
//   DEPTH        number of register stages (>= 1)
//   RESET_VALUE  value loaded into every data register on reset
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous active-high discard of all in-flight entries
//   in_valid   producer offers in_data
//   in_ready   pipeline accepts in_data (combinational from out_ready)
//   in_data    producer payload
//   out_valid  out_data holds a valid entry
//   out_ready  consumer accepts out_data
//   out_data   payload of the last stage
//   occupancy  number of valid stages, 0..DEPTH
module pipeline_register #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] open_c;
    logic [OCC_W-1:0] occ_c;

    // A stage is open when it, or any stage downstream of it, is empty, or
    // when the consumer is taking the last stage. Accumulating from the output
    // end avoids a self-referencing chain through open_c.
    always_comb begin : open_logic
        logic acc;
        acc    = out_ready;
        open_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            acc                = acc | ~valid_q[DEPTH-1-i];
            open_c[DEPTH-1-i]  = acc;
        end
    end

    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            // Only the valid bits are cleared; stale data is harmless.
            valid_d = '0;
        end else begin
            if (open_c[0]) begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (open_c[i]) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end
    end

    always_comb begin : popcount
        occ_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_c = occ_c + OCC_W'(valid_q[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // reset gates in_ready so nothing is offered as accepted while held in reset.
    assign in_ready  = open_c[0] & ~flush & reset;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_c;

endmodule

// File: tb/tb_pipeline_register.sv
// Testbench for pipeline_register (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
// Reference model: the pipeline is an ordered queue of accepted entries;
// the oldest entry is presented once it has been inside for DEPTH-1 edges,
// input is accepted whenever fewer than DEPTH entries are held or the
// consumer is ready, and flush/reset empty the queue.
module tb_pipeline_register;

    localparam int          W  = 8;
    localparam int          D  = 3;
    localparam logic [W-1:0] RV = 8'hA5;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    pipeline_register #(
        .WIDTH      (W),
        .DEPTH      (D),
        .RESET_VALUE(RV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data;
        int unsigned  acc;   // edge number at which the entry was accepted
    } ent_t;

    ent_t        exp_q[$];
    int unsigned ecount = 0;      // rising edges seen, updated on falling edges
    int          n_checks = 0;
    int          n_fail = 0;
    bit          exp_in_ready = 1'b0;
    bit          exp_out_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: predict and compare outputs mid-cycle, away from the rising edge.
    always @(negedge clock) begin
        ecount++;
        exp_out_valid = reset && !flush && exp_q.size() > 0 &&
                        (ecount - exp_q[0].acc >= D - 1);
        exp_in_ready  = reset && !flush && (exp_q.size() < D || out_ready);
        check("out_valid", 32'(out_valid), 32'(exp_out_valid));
        check("in_ready", 32'(in_ready), 32'(exp_in_ready));
        check("occupancy", 32'(occupancy), 32'(exp_q.size()));
        if (exp_out_valid) check("out_data", 32'(out_data), 32'(exp_q[0].data));
        if (!reset) check("reset_out_data", 32'(out_data), 32'(RV));
    end

    // Stimulus side of the scoreboard: record every accepted entry.
    always @(posedge clock) begin
        ent_t e;
        if (reset && exp_in_ready && in_valid) begin
            e.data = in_data;
            e.acc  = ecount + 1;
            exp_q.push_back(e);
        end
    end

    // Monitor side: retire on output transfer, discard on flush.
    always @(posedge clock) begin
        if (reset) begin
            if (flush) exp_q.delete();
            else if (exp_out_valid && out_ready) void'(exp_q.pop_front());
        end
    end

    always @(negedge reset) exp_q.delete();

    // Inputs given here apply to the next rising edge.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_now();
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        check("async_out_data", 32'(out_data), 32'(RV));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        #2 check_reset_now();
        @(posedge clock);
        #3;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        out_ready = 1'b1;
        reset     = 1'b1;

        // Streaming at full throughput, first accept on the first edge.
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: fill, stall, then simultaneous in/out while full.
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 8'h13, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with two entries in flight and competing input/output.
        drive(1'b1, 8'h30, 1'b0, 1'b0);
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        drive(1'b1, 8'h32, 1'b1, 1'b1);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Lone entry travels through idle stages and waits for the consumer.
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-flight between edges.
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_now();
        @(posedge clock);
        #3;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        flush     = 1'b0;
        reset     = 1'b1;
        drive(1'b1, 8'h78, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                  ($urandom % 40) == 0);
        end
        repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
